upconverter_fs4: RTL and testbench

//  Transmit-side counterpart of the fs/4 downconverter. Takes complex baseband
//  I/Q samples and mixes them up to a real passband stream at fs/4, sequence
//  y[n] = I,-Q,-I,Q,... Each accepted I/Q pair yields two real samples, emitted

---
 rtl/upconverter_fs4.sv | 179 +++++++++++++++++
 tb/tb_upconverter_fs4.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/upconverter_fs4.sv
// -----------------------------------------------------------------------------
// upconverter_fs4
//
// Mixes complex baseband I/Q up to a real passband stream at fs/4. The real
// sequence is y[n] = I, -Q, -I, Q, ... and each accepted I/Q pair produces two
// consecutive real samples, presented together as (inph, inph_delay). A
// matching fs/4 downconverter can therefore undo the mix sample-exact.
//
// Negation saturates: -(most negative) becomes the most positive value. Each
// saturated negation is counted in a sticky counter that holds at all-ones.
//
// Ports
//   i_clock            in   clock, rising edge
//   i_reset_n          in   asynchronous active-low reset
//   i_inph_data        in   baseband I, signed
//   i_quad_data        in   baseband Q, signed
//   i_valid            in   input beat valid
//   o_ready            out  input beat can be accepted (registered)
//   i_sync             in   phase restart, applies only to an accepted beat
//   o_inph_data        out  real sample n   (even index)
//   o_inph_delay_data  out  real sample n+1 (odd index)
//   o_valid            out  output beat valid
//   i_ready            in   downstream accepts the output beat
//   o_sat_count        out  number of saturated negations, sticky at max
// -----------------------------------------------------------------------------
module upconverter_fs4 #(
  parameter int DATA_WIDTH = 16,
  parameter int SAT_CNT_W  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_inph_data,
  input  logic [DATA_WIDTH-1:0] i_quad_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sync,
  output logic [DATA_WIDTH-1:0] o_inph_data,
  output logic [DATA_WIDTH-1:0] o_inph_delay_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SAT_CNT_W-1:0]  o_sat_count
);

  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // registered state
  logic                  ready_q,   ready_d;
  logic                  phase_q,   phase_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_i_q,   out_i_d;
  logic [DATA_WIDTH-1:0] out_d_q,   out_d_d;
  logic                  skd_vld_q, skd_vld_d;
  logic [DATA_WIDTH-1:0] skd_i_q,   skd_i_d;
  logic [DATA_WIDTH-1:0] skd_d_q,   skd_d_d;
  logic [SAT_CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

  // combinational helpers
  logic                  accept_in;
  logic                  accept_out;
  logic                  use_phase;
  logic [DATA_WIDTH-1:0] neg_i;
  logic [DATA_WIDTH-1:0] neg_q;
  logic                  sat_i;
  logic                  sat_q;
  logic [DATA_WIDTH-1:0] mix_i;
  logic [DATA_WIDTH-1:0] mix_d;
  logic                  sat_hit;

  assign accept_in  = i_valid && ready_q;
  assign accept_out = out_vld_q && i_ready;

  // ---------------------------------------------------------------------------
  // Mixer: sync forces the current beat onto phase 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    use_phase = i_sync ? 1'b0 : phase_q;

    sat_i = (i_inph_data == S_MIN);
    sat_q = (i_quad_data == S_MIN);
    neg_i = sat_i ? S_MAX : -i_inph_data;
    neg_q = sat_q ? S_MAX : -i_quad_data;

    mix_i   = i_inph_data;
    mix_d   = neg_q;
    sat_hit = sat_q;
    if (use_phase) begin
      mix_i   = neg_i;
      mix_d   = i_quad_data;
      sat_hit = sat_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry output buffer. The output register is always the head; the skid
  // register only fills when a beat arrives while the head is stalled. Because
  // o_ready is the registered "skid empty" flag, a beat can never arrive while
  // both entries are full.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_vld_d = out_vld_q;
    out_i_d   = out_i_q;
    out_d_d   = out_d_q;
    skd_vld_d = skd_vld_q;
    skd_i_d   = skd_i_q;
    skd_d_d   = skd_d_q;
    phase_d   = phase_q;
    sat_cnt_d = sat_cnt_q;

    if (accept_out) begin
      if (skd_vld_q) begin
        out_vld_d = 1'b1;
        out_i_d   = skd_i_q;
        out_d_d   = skd_d_q;
        skd_vld_d = accept_in;
        if (accept_in) begin
          skd_i_d = mix_i;
          skd_d_d = mix_d;
        end
      end else begin
        out_vld_d = accept_in;
        if (accept_in) begin
          out_i_d = mix_i;
          out_d_d = mix_d;
        end
      end
    end else if (accept_in) begin
      if (!out_vld_q) begin
        out_vld_d = 1'b1;
        out_i_d   = mix_i;
        out_d_d   = mix_d;
      end else begin
        skd_vld_d = 1'b1;
        skd_i_d   = mix_i;
        skd_d_d   = mix_d;
      end
    end

    if (accept_in) begin
      phase_d = ~use_phase;
      if (sat_hit && (sat_cnt_q != {SAT_CNT_W{1'b1}})) begin
        sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
      end
    end

    ready_d = ~skd_vld_d;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_q   <= 1'b0;
      phase_q   <= 1'b0;
      out_vld_q <= 1'b0;
      out_i_q   <= '0;
      out_d_q   <= '0;
      skd_vld_q <= 1'b0;
      skd_i_q   <= '0;
      skd_d_q   <= '0;
      sat_cnt_q <= '0;
    end else begin
      ready_q   <= ready_d;
      phase_q   <= phase_d;
      out_vld_q <= out_vld_d;
      out_i_q   <= out_i_d;
      out_d_q   <= out_d_d;
      skd_vld_q <= skd_vld_d;
      skd_i_q   <= skd_i_d;
      skd_d_q   <= skd_d_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_ready           = ready_q;
  assign o_valid           = out_vld_q;
  assign o_inph_data       = out_i_q;
  assign o_inph_delay_data = out_d_q;
  assign o_sat_count       = sat_cnt_q;

endmodule

// File: tb/tb_upconverter_fs4.sv
// -----------------------------------------------------------------------------
// tb_upconverter_fs4
//
// Directed bench for upconverter_fs4: latency, saturation, back-pressure,
// phase sync, reset mid-stream, and a seeded random stream recovered through a
// behavioural fs/4 downconverter.
// -----------------------------------------------------------------------------
module tb_upconverter_fs4;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        in_valid;
  logic        in_ready;
  logic        in_sync;
  logic [15:0] out_i;
  logic [15:0] out_d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int src_i [64];
  int src_q [64];
  bit src_s [64];
  int rcv_i [64];
  int rcv_d [64];

  upconverter_fs4 #(.DATA_WIDTH(16), .SAT_CNT_W(16)) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_inph_data       (in_i),
    .i_quad_data       (in_q),
    .i_valid           (in_valid),
    .o_ready           (in_ready),
    .i_sync            (in_sync),
    .o_inph_data       (out_i),
    .o_inph_delay_data (out_d),
    .o_valid           (out_valid),
    .i_ready           (out_ready),
    .o_sat_count       (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int neg_sat(input int x);
    return (x == -32768) ? 32767 : -x;
  endfunction

  // expected pair for a beat mixed on phase p
  function automatic int exp_inph(input int i, input bit p);
    return p ? neg_sat(i) : i;
  endfunction

  function automatic int exp_dly(input int q, input bit p);
    return p ? q : neg_sat(q);
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Drives src_* beats with given valid/ready percentages; i_ready is held low
  // for the first `stall` cycles. Collects output beats into rcv_*.
  task automatic stream(input int n, input int vpct, input int rpct,
                        input int stall, input int maxc,
                        output int acc_at_stall, output int rdy_at_stall,
                        output int got);
    int  sent = 0;
    int  cyc  = 0;
    bit  acc;
    got          = 0;
    acc_at_stall = 0;
    rdy_at_stall = 1;
    while (got < n && cyc < maxc) begin
      if (cyc == stall && stall > 0) begin
        acc_at_stall = sent;
        rdy_at_stall = int'(in_ready);
      end
      if (sent < n && $urandom_range(99) < vpct) begin
        in_valid = 1'b1;
        in_i     = 16'(src_i[sent]);
        in_q     = 16'(src_q[sent]);
        in_sync  = src_s[sent];
      end else begin
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_i     = 16'h0;
        in_q     = 16'h0;
      end
      out_ready = (cyc >= stall) && ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        rcv_i[got] = s16(out_i);
        rcv_d[got] = s16(out_d);
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int acc_s, rdy_s, got;
    bit p;
    int ri, rq;

    rst_n     = 1'b0;
    in_i      = '0;
    in_q      = '0;
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    out_ready = 1'b1;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_sat", int'(sat_cnt), 0);
    chk("rst_data", int'(out_i), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rel", int'(in_ready), 1);

    // ---- test 1: back-to-back, one-cycle latency
    in_valid = 1'b1; in_i = 16'd100; in_q = 16'd200;
    chk("t1_pre_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("t1_b0_valid", int'(out_valid), 1);
    chk("t1_b0_i", s16(out_i), 100);
    chk("t1_b0_d", s16(out_d), -200);
    in_i = 16'd300; in_q = 16'd400;
    @(posedge clk); #1;
    chk("t1_b1_i", s16(out_i), -300);
    chk("t1_b1_d", s16(out_d), 400);
    in_i = 16'd5; in_q = 16'd6;
    @(posedge clk); #1;
    chk("t1_b2_i", s16(out_i), 5);
    chk("t1_b2_d", s16(out_d), -6);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_idle_valid", int'(out_valid), 0);

    // ---- test 2: saturation on both phases
    in_valid = 1'b1; in_sync = 1'b1; in_i = 16'h8000; in_q = 16'h8000;
    @(posedge clk); #1;
    chk("t2_p0_i", s16(out_i), -32768);
    chk("t2_p0_d", s16(out_d), 32767);
    chk("t2_cnt1", int'(sat_cnt), 1);
    in_sync = 1'b0;
    @(posedge clk); #1;
    chk("t2_p1_i", s16(out_i), 32767);
    chk("t2_p1_d", s16(out_d), -32768);
    chk("t2_cnt2", int'(sat_cnt), 2);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // ---- test 3: back-pressure, phase now 0
    src_i[0] = 10; src_q[0] = 20; src_s[0] = 0;
    src_i[1] = 30; src_q[1] = 40; src_s[1] = 0;
    src_i[2] = 50; src_q[2] = 60; src_s[2] = 0;
    src_i[3] = 70; src_q[3] = 80; src_s[3] = 0;
    stream(4, 100, 100, 6, 60, acc_s, rdy_s, got);
    chk("t3_acc_stalled", acc_s, 2);
    chk("t3_ready_stalled", rdy_s, 0);
    chk("t3_got", got, 4);
    chk("t3_b0_i", rcv_i[0], 10);   chk("t3_b0_d", rcv_d[0], -20);
    chk("t3_b1_i", rcv_i[1], -30);  chk("t3_b1_d", rcv_d[1], 40);
    chk("t3_b2_i", rcv_i[2], 50);   chk("t3_b2_d", rcv_d[2], -60);
    chk("t3_b3_i", rcv_i[3], -70);  chk("t3_b3_d", rcv_d[3], 80);
    @(posedge clk); #1;
    chk("t3_ready_back", int'(in_ready), 1);
    chk("t3_drained", int'(out_valid), 0);

    // ---- test 4: sync on third beat (phase now 0)
    src_i[0] = 9; src_q[0] = 9; src_s[0] = 0;
    stream(1, 100, 100, 0, 20, acc_s, rdy_s, got);
    chk("t4_dummy_i", rcv_i[0], 9);
    chk("t4_dummy_d", rcv_d[0], -9);
    in_sync = 1'b1;   // not accepted, must be ignored
    @(posedge clk); #1;
    in_sync = 1'b0;
    src_i[0] = 1; src_q[0] = 2; src_s[0] = 0;
    src_i[1] = 3; src_q[1] = 4; src_s[1] = 0;
    src_i[2] = 5; src_q[2] = 6; src_s[2] = 1;
    src_i[3] = 7; src_q[3] = 8; src_s[3] = 0;
    stream(4, 100, 100, 0, 40, acc_s, rdy_s, got);
    chk("t4_got", got, 4);
    chk("t4_b0_i", rcv_i[0], -1);  chk("t4_b0_d", rcv_d[0], 2);
    chk("t4_b1_i", rcv_i[1], 3);   chk("t4_b1_d", rcv_d[1], -4);
    chk("t4_b2_i", rcv_i[2], 5);   chk("t4_b2_d", rcv_d[2], -6);
    chk("t4_b3_i", rcv_i[3], -7);  chk("t4_b3_d", rcv_d[3], 8);

    // ---- test 6: reset with two beats buffered (phase now 0)
    out_ready = 1'b0;
    in_valid = 1'b1; in_i = 16'd11; in_q = 16'd12;
    @(posedge clk); #1;
    in_i = 16'd13; in_q = 16'd14;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_full_ready", int'(in_ready), 0);
    chk("t6_full_valid", int'(out_valid), 1);
    chk("t6_held_i", s16(out_i), 11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_sat", int'(sat_cnt), 0);
    chk("t6_rst_ready", int'(in_ready), 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_rel", int'(in_ready), 1);
    in_valid = 1'b1; in_i = 16'd7; in_q = 16'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_first_valid", int'(out_valid), 1);
    chk("t6_first_i", s16(out_i), 7);
    chk("t6_first_d", s16(out_d), -8);
    @(posedge clk); #1;

    // ---- test 5: random handshakes, recovered through an fs/4 downconverter
    for (int k = 0; k < 40; k++) begin
      src_i[k] = int'($urandom_range(60000)) - 30000;
      src_q[k] = int'($urandom_range(60000)) - 30000;
      src_s[k] = (k == 0);
    end
    stream(40, 70, 60, 0, 2000, acc_s, rdy_s, got);
    chk("t5_got", got, 40);
    for (int k = 0; k < 40; k++) begin
      p = k[0];
      chk($sformatf("t5_mix_i%0d", k), rcv_i[k], exp_inph(src_i[k], p));
      chk($sformatf("t5_mix_d%0d", k), rcv_d[k], exp_dly(src_q[k], p));
      ri = p ? -rcv_i[k] : rcv_i[k];
      rq = p ? rcv_d[k] : -rcv_d[k];
      chk($sformatf("t5_rec_i%0d", k), ri, src_i[k]);
      chk($sformatf("t5_rec_q%0d", k), rq, src_q[k]);
    end
    chk("t5_no_sat", int'(sat_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
